// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: memory-wait FSM, load-use bubbles and branch flushes.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
package controlmux;
  typedef enum logic {zero = 1'b0, ctrl = 1'b1} controlmux_sel_t;
endpackage

module hazard_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4:0]                  id_rs1_i,
  input  logic [4:0]                  id_rs2_i,
  input  logic                        id_uses_rs1_i,
  input  logic                        id_uses_rs2_i,
  input  logic                        ex_mem_read_i,
  input  logic [4:0]                  ex_rd_i,
  input  logic                        imem_req_i,
  input  logic                        imem_resp_i,
  input  logic                        dmem_req_i,
  input  logic                        dmem_resp_i,
  input  logic                        br_taken_i,
  output logic                        pc_load_o,
  output logic                        if_id_load_o,
  output logic                        id_ex_load_o,
  output logic                        ex_mem_load_o,
  output logic                        mem_wb_load_o,
  output logic                        if_id_flush_o,
  output controlmux::controlmux_sel_t controlmux_sel_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]        stall_cycles_o,
  output logic [CNT_WIDTH-1:0]        bubble_cnt_o
`endif
);

  typedef enum logic {StRun, StMemWait} state_e;

  state_e state_q;
  logic   i_done_q, d_done_q;
  logic   wait_sat, mem_stall, load_use;

  // Sticky bits are only ever set while waiting, so in StRun this reduces to the entry test.
  assign wait_sat  = (!imem_req_i || i_done_q || imem_resp_i) &&
                     (!dmem_req_i || d_done_q || dmem_resp_i);
  assign mem_stall = !wait_sat;
  assign load_use  = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                     ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                      (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    pc_load_o        = 1'b0;
    if_id_load_o     = 1'b0;
    id_ex_load_o     = 1'b0;
    ex_mem_load_o    = 1'b0;
    mem_wb_load_o    = 1'b0;
    if_id_flush_o    = 1'b0;
    controlmux_sel_o = controlmux::zero;
    if (!rst) begin
      controlmux_sel_o = controlmux::zero;
    end else if (mem_stall) begin
      controlmux_sel_o = controlmux::ctrl;
    end else if (br_taken_i) begin
      {pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o} = 5'b11111;
      if_id_flush_o = 1'b1;
    end else if (load_use) begin
      {id_ex_load_o, ex_mem_load_o, mem_wb_load_o} = 3'b111;
    end else begin
      {pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o} = 5'b11111;
      controlmux_sel_o = controlmux::ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StRun;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
`ifdef HAZARD_PERF_EN
      stall_cycles_o <= '0;
      bubble_cnt_o   <= '0;
`endif
    end else begin
      if (wait_sat) begin
        state_q  <= StRun;
        i_done_q <= 1'b0;
        d_done_q <= 1'b0;
      end else begin
        // Capture responses even on the entry edge so an early pulse is not lost.
        state_q <= StMemWait;
        if (imem_req_i && imem_resp_i) i_done_q <= 1'b1;
        if (dmem_req_i && dmem_resp_i) d_done_q <= 1'b1;
      end
`ifdef HAZARD_PERF_EN
      if (mem_stall) stall_cycles_o <= stall_cycles_o + 1'b1;
      else if (br_taken_i || load_use) bubble_cnt_o <= bubble_cnt_o + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; counter checks run when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       id_uses_rs1_i, id_uses_rs2_i, ex_mem_read_i;
  logic       imem_req_i, imem_resp_i, dmem_req_i, dmem_resp_i, br_taken_i;
  logic       pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o;
  logic       if_id_flush_o;
  controlmux::controlmux_sel_t controlmux_sel_o;
`ifdef HAZARD_PERF_EN
  logic [3:0] stall_cycles_o, bubble_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb, flush, sel}
  localparam logic [6:0] Norm  = 7'b11111_0_1;
  localparam logic [6:0] Stall = 7'b00000_0_1;
  localparam logic [6:0] Br    = 7'b11111_1_0;
  localparam logic [6:0] Lu    = 7'b00111_0_0;
  localparam logic [6:0] Rst   = 7'b00000_0_0;

  hazard_ctrl #(.CNT_WIDTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_uses_rs1_i    (id_uses_rs1_i),
    .id_uses_rs2_i    (id_uses_rs2_i),
    .ex_mem_read_i    (ex_mem_read_i),
    .ex_rd_i          (ex_rd_i),
    .imem_req_i       (imem_req_i),
    .imem_resp_i      (imem_resp_i),
    .dmem_req_i       (dmem_req_i),
    .dmem_resp_i      (dmem_resp_i),
    .br_taken_i       (br_taken_i),
    .pc_load_o        (pc_load_o),
    .if_id_load_o     (if_id_load_o),
    .id_ex_load_o     (id_ex_load_o),
    .ex_mem_load_o    (ex_mem_load_o),
    .mem_wb_load_o    (mem_wb_load_o),
    .if_id_flush_o    (if_id_flush_o),
    .controlmux_sel_o (controlmux_sel_o)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles_o   (stall_cycles_o),
    .bubble_cnt_o     (bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [6:0] exp);
    check(tag, 64'({pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o,
                    if_id_flush_o, logic'(controlmux_sel_o)}), 64'(exp));
  endtask

  // Advance to the next negedge, clearing all stimulus to an idle pipeline.
  task automatic next_idle();
    @(negedge clk);
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; ex_mem_read_i = 1'b0;
    imem_req_i = 1'b0; imem_resp_i = 1'b0; dmem_req_i = 1'b0; dmem_resp_i = 1'b0;
    br_taken_i = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_uses_rs2_i = 1'b1;
  endtask

  task automatic check_run_state(input string tag);
    check({tag, "_state"}, 64'(dut.state_q), 64'd0);
    check({tag, "_idone"}, 64'(dut.i_done_q), 64'd0);
    check({tag, "_ddone"}, 64'(dut.d_done_q), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    next_idle(); rst = 1'b0; #1;
    check_outs("reset_forced", Rst);
    next_idle(); rst = 1'b1; #1;
    check_outs("after_reset", Norm);
    check_run_state("after_reset");

    // Load-use bubble: one cycle, then EX holds the nop.
    next_idle(); set_load_use(); #1;
    check_outs("load_use", Lu);
    next_idle(); #1;
    check_outs("load_use_clear", Norm);
    next_idle(); ex_mem_read_i = 1'b1; id_rs1_i = 5'd0; id_uses_rs1_i = 1'b1; #1;
    check_outs("load_use_x0", Norm);
    next_idle(); ex_mem_read_i = 1'b1; ex_rd_i = 5'd7; id_rs1_i = 5'd7; #1;
    check_outs("load_use_unused_src", Norm);
    next_idle(); ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_uses_rs1_i = 1'b1; #1;
    check_outs("no_load_no_hazard", Norm);

    // Taken branch.
    next_idle(); br_taken_i = 1'b1; #1;
    check_outs("branch", Br);
    next_idle(); #1;
    check_outs("branch_next", Norm);

    // Stray response without a request.
    next_idle(); imem_resp_i = 1'b1; dmem_resp_i = 1'b1; #1;
    check_outs("stray_resp", Norm);

    // Dual memory wait: I resp at cycle 3, D resp at cycle 7.
    for (int c = 0; c < 8; c++) begin
      next_idle(); imem_req_i = 1'b1; dmem_req_i = 1'b1;
      imem_resp_i = (c == 3); dmem_resp_i = (c == 7); #1;
      check_outs($sformatf("dual_wait_c%0d", c), (c == 7) ? Norm : Stall);
      if (c == 4) check("dual_wait_isticky", 64'(dut.i_done_q), 64'd1);
    end
    next_idle(); #1;
    check_outs("dual_wait_c8", Norm);
    check_run_state("dual_wait_c8");

    // Branch plus load-use resolves as branch only.
    next_idle(); set_load_use(); br_taken_i = 1'b1; #1;
    check_outs("branch_and_lu", Br);

    // Load-use deferred through a 4-cycle D-side wait.
    for (int c = 0; c < 4; c++) begin
      next_idle(); set_load_use(); dmem_req_i = 1'b1; dmem_resp_i = (c == 3); #1;
      check_outs($sformatf("lu_in_wait_c%0d", c), (c == 3) ? Lu : Stall);
    end
    next_idle(); #1;
    check_outs("lu_in_wait_after", Norm);

    // Reset mid-wait.
    next_idle(); imem_req_i = 1'b1; #1;
    check_outs("pre_reset_wait", Stall);
    next_idle(); imem_req_i = 1'b1; #1;
    check("in_mem_wait", 64'(dut.state_q), 64'd1);
    rst = 1'b0; #1;
    check_outs("reset_mid_wait", Rst);
    next_idle(); rst = 1'b1; #1;
    check_outs("reset_release", Norm);
    check_run_state("reset_release");
`ifdef HAZARD_PERF_EN
    check("stall_cnt_reset", 64'(stall_cycles_o), 64'd0);
    check("bubble_cnt_reset", 64'(bubble_cnt_o), 64'd0);

    // Three stall cycles then two bubbles.
    for (int c = 0; c < 4; c++) begin
      next_idle(); dmem_req_i = 1'b1; dmem_resp_i = (c == 3);
    end
    next_idle(); br_taken_i = 1'b1;
    next_idle(); set_load_use();
    next_idle(); #1;
    check("stall_cnt", 64'(stall_cycles_o), 64'd3);
    check("bubble_cnt", 64'(bubble_cnt_o), 64'd2);

    // Thirteen more stalls wrap the 4-bit counter from 15 to 0.
    for (int c = 0; c < 14; c++) begin
      next_idle(); imem_req_i = 1'b1; imem_resp_i = (c == 13);
    end
    next_idle(); #1;
    check("stall_cnt_wrap", 64'(stall_cycles_o), 64'd0);
    check("bubble_cnt_hold", 64'(bubble_cnt_o), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
